// File: rtl/axi_stream_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header insert/remove blocks.
// State encodings plus keep-vector decoding used by both directions.
package axi_stream_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        STREAM,
        TAIL
    } hdr_state_e;

    localparam int MAX_BYTES = 64;

    // Length of the MSB-contiguous run of ones within the low nb bits.
    function automatic int keep_run(
        input logic [MAX_BYTES-1:0] keep,
        input int                   nb
    );
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = MAX_BYTES - 1; i >= 0; i--) begin
            if (i < nb) begin
                if (run && keep[i]) n++;
                else run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Byte re-packing datapath: joins the left-aligned residue with a new beat
// shifted right by the residue length, and returns the bytes that spill over.
module axis_byte_merge
    import axi_stream_hdr_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int CNT_WD  = 3
) (
    input  logic [DATA_WD-1:0] residue,
    input  logic [DATA_WD-1:0] data_in,
    input  logic [CNT_WD-1:0]  r_cnt,
    output logic [DATA_WD-1:0] merged,
    output logic [DATA_WD-1:0] leftover
);

    localparam int NB = DATA_WD / 8;

    logic [CNT_WD-1:0] h_cnt;

    // A shift by the full bus width yields zero, which covers r_cnt == 0.
    always_comb begin
        h_cnt    = CNT_WD'(NB) - r_cnt;
        merged   = residue | (data_in >> {r_cnt, 3'b000});
        leftover = data_in << {h_cnt, 3'b000};
    end

endmodule

// File: rtl/axi_stream_remove_header.sv
// Strips a per-packet header of 1..DATA_BYTE_WD bytes from an AXI-Stream
// and re-packs the remaining payload into full, MSB-first beats.
module axi_stream_remove_header
    import axi_stream_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    output logic                    ready_remove
);

    localparam int CW = BYTE_CNT_WD + 1;
    localparam int NB = DATA_BYTE_WD;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t NB_C = cnt_t'(NB);

    function automatic logic [NB-1:0] top_mask(input cnt_t n);
        return ~({NB{1'b1}} >> n);
    endfunction

    hdr_state_e          state_q, state_d;
    cnt_t                r_q, r_d;
    logic [DATA_WD-1:0]  residue_q, residue_d;
    logic                valid_q, valid_d;
    logic [DATA_WD-1:0]  data_q, data_d;
    logic [NB-1:0]       keep_q, keep_d;
    logic                last_q, last_d;

    cnt_t                k_cnt;
    cnt_t                sum;
    logic [NB-1:0]       k_mask;
    logic [DATA_WD-1:0]  data_m;
    logic [DATA_WD-1:0]  merged;
    logic [DATA_WD-1:0]  leftover;
    logic                out_free;

    // Bytes past the valid run of a last beat are zeroed before merging.
    always_comb begin
        k_cnt = NB_C;
        if (last_in) k_cnt = cnt_t'(keep_run(MAX_BYTES'(keep_in), NB));
        k_mask = top_mask(k_cnt);
        for (int i = 0; i < NB; i++) begin
            data_m[8*i +: 8] = data_in[8*i +: 8] & {8{k_mask[i]}};
        end
        sum      = r_q + k_cnt;
        out_free = !valid_q || ready_out;
    end

    axis_byte_merge #(
        .DATA_WD (DATA_WD),
        .CNT_WD  (CW)
    ) u_merge (
        .residue  (residue_q),
        .data_in  (data_m),
        .r_cnt    (r_q),
        .merged   (merged),
        .leftover (leftover)
    );

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        residue_d    = residue_q;
        valid_d      = valid_q && !ready_out;
        data_d       = data_q;
        keep_d       = keep_q;
        last_d       = last_q;
        ready_in     = 1'b0;
        ready_remove = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_remove = 1'b1;
                if (valid_remove) begin
                    r_d     = NB_C - cnt_t'(byte_remove_cnt) - cnt_t'(1);
                    state_d = FIRST;
                end
            end
            FIRST: begin
                ready_in = out_free;
                if (valid_in && out_free) begin
                    residue_d = leftover;
                    if (!last_in) begin
                        state_d = STREAM;
                    end else if (sum > NB_C) begin
                        r_d     = sum - NB_C;
                        state_d = TAIL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            STREAM: begin
                ready_in = out_free;
                if (valid_in && out_free) begin
                    valid_d   = 1'b1;
                    data_d    = merged;
                    residue_d = leftover;
                    keep_d    = '1;
                    last_d    = 1'b0;
                    if (last_in) begin
                        if (sum > NB_C) begin
                            r_d     = sum - NB_C;
                            state_d = TAIL;
                        end else begin
                            keep_d  = top_mask(sum);
                            last_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            TAIL: begin
                if (out_free) begin
                    valid_d = 1'b1;
                    data_d  = residue_q;
                    keep_d  = top_mask(r_q);
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            residue_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            residue_q <= residue_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;

endmodule

// File: doc/axi_stream_remove_header.md
AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), width of byte_remove_cnt.
REQ-004 SHALL have ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
valid_in  input  1  upstream beat valid.
data_in  input  DATA_WD  upstream data; byte DATA_BYTE_WD-1 (MSB) is first in stream order.
keep_in  input  DATA_BYTE_WD  byte enables; all ones except on last beat, where they are MSB-contiguous.
last_in  input  1  last beat of packet.
ready_in  output  1  upstream beat accepted when valid_in && ready_in.
valid_out  output  1  downstream beat valid.
data_out  output  DATA_WD  packed output data, MSB-first.
keep_out  output  DATA_BYTE_WD  all ones except last beat (MSB-contiguous).
last_out  output  1  last beat of output packet.
ready_out  input  1  downstream ready.
valid_remove  input  1  removal descriptor valid.
byte_remove_cnt  input  BYTE_CNT_WD  header length H = byte_remove_cnt+1 bytes (1..DATA_BYTE_WD).
ready_remove  output  1  descriptor accepted when valid_remove && ready_remove.

Function
REQ-005 SHALL strip the first H bytes of each input packet and emit the remaining bytes re-packed into full beats.
REQ-006 SHALL use FSM states IDLE, FIRST, STREAM, TAIL; ready_remove = 1 only in IDLE.
REQ-007 IDLE: on descriptor handshake latch H, go to FIRST; ready_in = 0.
REQ-008 FIRST: ready_in = 1 when the output register is empty or ready_out is 1; accept first beat, store its trailing DATA_BYTE_WD-H bytes as residue (count R = DATA_BYTE_WD-H); no output beat; go to STREAM, or TAIL if last_in and remaining bytes > 0, or IDLE if last_in and remaining bytes <= 0 (packet dropped).
REQ-009 STREAM: ready_in = !valid_out || ready_out; each accepted beat emits {residue R bytes, first DATA_BYTE_WD-R input bytes} and stores the leftover R bytes as the new residue.
REQ-010 STREAM with last_in having k valid bytes: if R+k <= DATA_BYTE_WD, emit one beat, keep_out = top R+k bits set, last_out = 1, go to IDLE; else emit a full beat, last_out = 0, go to TAIL.
REQ-011 TAIL: ready_in = 0; emit residue as final beat, keep_out MSB-contiguous, last_out = 1; go to IDLE when the beat is loaded into the output register.
REQ-012 When H = DATA_BYTE_WD (R = 0), first beat is dropped and later beats pass through unchanged with one cycle of latency.
REQ-013 Outputs SHALL be registered; latency from an accepted input beat to its valid_out is 1 cycle; sustained throughput is 1 beat/clk when ready_out is held 1.
REQ-014 While valid_out && !ready_out, data_out, keep_out, last_out SHALL remain stable (AXI-Stream rule); valid_out SHALL NOT drop without a handshake.
REQ-015 Invalid keep_in patterns SHALL be treated as keep_in = all ones (non-last) or counted by MSB-contiguous run length (last).
REQ-016 A descriptor offered while not in IDLE SHALL wait; input beats offered in IDLE SHALL wait.

Reset
REQ-017 With rst = 1 at a rising edge: state IDLE, residue and R cleared, valid_out = 0, data_out = 0, keep_out = 0, last_out = 0; ready_in = 0.
REQ-018 Reset asserted mid-packet SHALL abandon the packet; no partial output beat after reset deasserts.

Structure
REQ-019 Shared package axi_stream_hdr_pkg SHALL hold state encodings and a keep-to-byte-count function, shared with axi_stream_insert_header.
REQ-020 Byte-merge datapath (residue + input, shift by R) SHALL be the combinational sub-module axis_byte_merge.

Verification (DATA_WD = 32)
REQ-021 cnt=1; beats AABBCCDD, 11223344, 5566xxxx keep 1100 last -> CCDD1122, 33445566 keep 1111 last.
REQ-022 cnt=0; beats AABBCCDD, 11223344 last -> BBCCDD11, 223344xx keep 1110 last via TAIL; ready_in low that cycle.
REQ-023 cnt=3; beats AABBCCDD, 11223344, 55667788 last -> 11223344, 55667788 last (pass-through).
REQ-024 cnt=1; single beat AABBCCDD keep 1100 last -> no output; ready_remove = 1 next cycle.
REQ-025 ready_out low 5 cycles mid-packet -> outputs stable, no byte lost or duplicated; random 100-packet run matches reference model.
REQ-026 rst pulsed in STREAM -> all outputs 0 next cycle; next packet processed correctly.
